// File: rtl/pb_alloc_pkg.sv
// Shared constants for the packet-buffer free-line allocator.
// The sizes match the packet-buffer arbiter and scoreboard.
package pb_alloc_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PORT_ASZ  = 2;
  localparam int PB_DEPTH  = 64;
  localparam int PB_ASZ    = 6;
  localparam int QUOTA     = 24;

  typedef logic [PB_ASZ:0] cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(PB_DEPTH);
  localparam cnt_t QUOTA_CNT = cnt_t'(QUOTA);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/pb_alloc_if.sv
// Allocation and free handshakes between the write/read ports and pb_alloc.
interface pb_alloc_if;
  import pb_alloc_pkg::*;

  logic [NUM_PORTS-1:0] alloc_srdy;
  logic [NUM_PORTS-1:0] alloc_drdy;
  logic [PB_ASZ-1:0]    alloc_addr;
  logic                 free_srdy;
  logic                 free_drdy;
  logic [PB_ASZ-1:0]    free_addr;
  logic [PORT_ASZ-1:0]  free_port;

  modport master (
    output alloc_srdy, free_srdy, free_addr, free_port,
    input  alloc_drdy, alloc_addr, free_drdy
  );

  modport slave (
    input  alloc_srdy, free_srdy, free_addr, free_port,
    output alloc_drdy, alloc_addr, free_drdy
  );

endinterface

// File: rtl/pb_rr_arb.sv
// Round-robin pick among eligible ports.
// The search starts at rr_ptr and produces a one-hot grant plus the encoded winner.
module pb_rr_arb
  import pb_alloc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] elig,
  input  logic [PORT_ASZ-1:0]  rr_ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_ASZ-1:0]  winner,
  output logic                 valid
);

  logic [PORT_ASZ-1:0] idx;

  // NUM_PORTS is a power of two, so the index wraps by truncation.
  always_comb begin
    gnt    = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = rr_ptr + PORT_ASZ'(i);
      if (!valid && elig[idx]) begin
        gnt[idx] = 1'b1;
        winner   = idx;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pb_alloc.sv
// Free-line allocator for the shared packet buffer.
// It keeps a circular free list with per-port quotas and grants lines round-robin.
module pb_alloc
  import pb_alloc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  pb_alloc_if.slave        bus,
  output logic             init_done,
  output logic [PB_ASZ:0]  free_count,
  output logic             err
);

  logic [0:0]           state;
  logic [PB_ASZ-1:0]    head;
  logic [PB_ASZ-1:0]    tail;
  logic [PORT_ASZ-1:0]  rr_ptr;
  cnt_t                 port_used [NUM_PORTS];
  logic [PB_ASZ-1:0]    list [PB_DEPTH];

  logic                 run;
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] gnt;
  logic [PORT_ASZ-1:0]  winner;
  logic                 alloc_fire;
  logic                 free_fire;
  logic                 free_bad;
  logic                 free_ok;

  assign run = (state == ST_RUN);

  // An empty list blocks every port, so a same-cycle free cannot bypass into a grant.
  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig[p] = run && bus.alloc_srdy[p] && (port_used[p] < QUOTA_CNT)
                && (free_count != '0);
    end
  end

  pb_rr_arb u_arb (
    .elig   (elig),
    .rr_ptr (rr_ptr),
    .gnt    (gnt),
    .winner (winner),
    .valid  (alloc_fire)
  );

  assign bus.alloc_drdy = gnt;
  assign bus.alloc_addr = list[head];
  assign bus.free_drdy  = run;
  assign init_done      = run;

  assign free_fire = run && bus.free_srdy;
  assign free_bad  = (free_count == DEPTH_CNT) || (port_used[bus.free_port] == '0);
  assign free_ok   = free_fire && !free_bad;

  // During INIT, tail walks the list once and wraps back to head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      head       <= '0;
      tail       <= '0;
      rr_ptr     <= '0;
      free_count <= '0;
      err        <= 1'b0;
    end else if (!run) begin
      tail       <= tail + PB_ASZ'(1);
      free_count <= free_count + cnt_t'(1);
      if (tail == PB_ASZ'(PB_DEPTH - 1)) begin
        state <= ST_RUN;
      end
    end else begin
      if (alloc_fire) begin
        head   <= head + PB_ASZ'(1);
        rr_ptr <= winner + PORT_ASZ'(1);
      end
      if (free_ok) begin
        tail <= tail + PB_ASZ'(1);
      end
      if (free_fire && free_bad) begin
        err <= 1'b1;
      end
      free_count <= free_count + cnt_t'(free_ok) - cnt_t'(alloc_fire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        port_used[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        port_used[p] <= port_used[p]
                        + cnt_t'(alloc_fire && (winner == PORT_ASZ'(p)))
                        - cnt_t'(free_ok && (bus.free_port == PORT_ASZ'(p)));
      end
    end
  end

  // The list contents need no reset because INIT rewrites every entry.
  always_ff @(posedge clk) begin
    if (!run) begin
      list[tail] <= tail;
    end else if (free_ok) begin
      list[tail] <= bus.free_addr;
    end
  end

endmodule

// File: tb/tb_pb_alloc.sv
// Testbench for pb_alloc: vector table, directed corner sequences and random traffic.
// Each cycle is checked against a queue-based reference model.
module tb_pb_alloc;
  import pb_alloc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic init_done;
  logic [PB_ASZ:0] free_count;
  logic err;

  pb_alloc_if bus();

  pb_alloc dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .init_done  (init_done),
    .free_count (free_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int addr;
    int port;
  } line_t;

  int    m_free_q[$];
  int    m_used[NUM_PORTS];
  int    m_rr;
  bit    m_err;
  int    m_init_cnt;
  bit    m_run;
  line_t m_out[$];

  logic [NUM_PORTS-1:0] e_drdy;
  int                   e_win;

  typedef struct {
    logic [3:0] srdy;
    logic [3:0] exp_drdy;
    int         exp_addr;
    int         exp_count;
  } vec_t;

  vec_t vecs[6];

  task automatic checkVal(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    m_free_q.delete();
    m_out.delete();
    for (int p = 0; p < NUM_PORTS; p++) m_used[p] = 0;
    m_rr       = 0;
    m_err      = 1'b0;
    m_init_cnt = 0;
    m_run      = 1'b0;
  endfunction

  function automatic void modelExpect();
    int p;
    e_drdy = '0;
    e_win  = -1;
    if (m_run && m_free_q.size() > 0) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        p = (m_rr + k) % NUM_PORTS;
        if (e_win < 0 && bus.alloc_srdy[p] && m_used[p] < QUOTA) begin
          e_drdy[p] = 1'b1;
          e_win     = p;
        end
      end
    end
  endfunction

  function automatic void modelStep();
    bit    ok;
    int    fp;
    line_t l;
    if (!m_run) begin
      m_init_cnt++;
      if (m_init_cnt == PB_DEPTH) begin
        m_run = 1'b1;
        for (int i = 0; i < PB_DEPTH; i++) m_free_q.push_back(i);
      end
    end else begin
      ok = 1'b0;
      fp = int'(bus.free_port);
      if (bus.free_srdy) begin
        if (m_free_q.size() == PB_DEPTH || m_used[fp] == 0) m_err = 1'b1;
        else ok = 1'b1;
      end
      if (e_win >= 0) begin
        l.addr = m_free_q.pop_front();
        l.port = e_win;
        m_out.push_back(l);
        m_used[e_win]++;
        m_rr = (e_win + 1) % NUM_PORTS;
      end
      if (ok) begin
        m_free_q.push_back(int'(bus.free_addr));
        m_used[fp]--;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [3:0] srdy, input bit fs, input int fa, input int fp);
    bus.alloc_srdy = srdy;
    bus.free_srdy  = fs;
    bus.free_addr  = PB_ASZ'(fa);
    bus.free_port  = PORT_ASZ'(fp);
  endtask

  task automatic checkOutput();
    @(negedge clk);
    modelExpect();
    checkVal("alloc_drdy", int'(bus.alloc_drdy), int'(e_drdy));
    if (e_win >= 0) checkVal("alloc_addr", int'(bus.alloc_addr), m_free_q[0]);
    checkVal("free_drdy", int'(bus.free_drdy), int'(m_run));
    checkVal("init_done", int'(init_done), int'(m_run));
    checkVal("free_count", int'(free_count), m_run ? m_free_q.size() : m_init_cnt);
    checkVal("err", int'(err), int'(m_err));
  endtask

  task automatic endCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic runCycle(input logic [3:0] srdy, input bit fs, input int fa, input int fp);
    applyStimulus(srdy, fs, fa, fp);
    checkOutput();
    endCycle();
  endtask

  task automatic doReset(input bit wait_init);
    reset = 1'b0;
    modelReset();
    applyStimulus(4'b0000, 1'b0, 0, 0);
    #2;
    checkVal("rst_init_done", int'(init_done), 0);
    checkVal("rst_free_count", int'(free_count), 0);
    checkVal("rst_alloc_drdy", int'(bus.alloc_drdy), 0);
    checkVal("rst_free_drdy", int'(bus.free_drdy), 0);
    checkVal("rst_err", int'(err), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    if (wait_init) begin
      for (int i = 0; i < PB_DEPTH; i++) begin
        checkOutput();
        endCycle();
      end
      checkVal("init_done_at_64", int'(init_done), 1);
      checkVal("init_free_count", int'(free_count), PB_DEPTH);
      checkVal("init_err", int'(err), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int         guard;
    logic [3:0] r_srdy;
    bit         r_fs;
    int         r_fa;
    int         r_fp;
    int         r_idx;

    vecs[0] = '{4'hf, 4'b0001, 0, 64};
    vecs[1] = '{4'hf, 4'b0010, 1, 63};
    vecs[2] = '{4'hf, 4'b0100, 2, 62};
    vecs[3] = '{4'hf, 4'b1000, 3, 61};
    vecs[4] = '{4'hf, 4'b0001, 4, 60};
    vecs[5] = '{4'hf, 4'b0010, 5, 59};

    doReset(1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].srdy, 1'b0, 0, 0);
      checkOutput();
      checkVal($sformatf("vec%0d_drdy", i), int'(bus.alloc_drdy), int'(vecs[i].exp_drdy));
      checkVal($sformatf("vec%0d_addr", i), int'(bus.alloc_addr), vecs[i].exp_addr);
      checkVal($sformatf("vec%0d_count", i), int'(free_count), vecs[i].exp_count);
      endCycle();
    end

    // Port 0 alone runs into its quota after 24 lines.
    doReset(1'b1);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(4'b0001, 1'b0, 0, 0);
      checkOutput();
      if (i < 24) begin
        checkVal("p0_drdy", int'(bus.alloc_drdy), 1);
        checkVal("p0_addr", int'(bus.alloc_addr), i);
      end else begin
        checkVal("p0_quota_drdy", int'(bus.alloc_drdy), 0);
        checkVal("p0_quota_count", int'(free_count), 40);
      end
      endCycle();
    end

    guard = 0;
    while (free_count != 0 && guard < 100) begin
      runCycle(4'b0110, 1'b0, 0, 0);
      guard++;
    end
    checkVal("drain_empty", int'(free_count), 0);

    applyStimulus(4'b0100, 1'b1, 7, 0);
    checkOutput();
    checkVal("empty_no_grant", int'(bus.alloc_drdy), 0);
    endCycle();
    applyStimulus(4'b0100, 1'b0, 0, 0);
    checkOutput();
    checkVal("refill_grant", int'(bus.alloc_drdy), 4);
    checkVal("refill_addr", int'(bus.alloc_addr), 7);
    endCycle();

    runCycle(4'b0000, 1'b1, 3, 0);
    applyStimulus(4'b0100, 1'b1, 9, 1);
    checkOutput();
    checkVal("simul_grant", int'(bus.alloc_drdy), 4);
    checkVal("simul_addr", int'(bus.alloc_addr), 3);
    checkVal("simul_count_before", int'(free_count), 1);
    endCycle();
    applyStimulus(4'b0000, 1'b0, 0, 0);
    checkOutput();
    checkVal("simul_count_after", int'(free_count), 1);
    endCycle();

    // Freeing on behalf of a port that holds nothing is an error.
    doReset(1'b1);
    runCycle(4'b0001, 1'b0, 0, 0);
    runCycle(4'b0001, 1'b0, 0, 0);
    runCycle(4'b0000, 1'b1, 0, 3);
    applyStimulus(4'b0000, 1'b0, 0, 0);
    checkOutput();
    checkVal("bad_free_err", int'(err), 1);
    checkVal("bad_free_count", int'(free_count), 62);
    endCycle();

    doReset(1'b0);
    for (int i = 0; i < 10; i++) runCycle(4'b0000, 1'b0, 0, 0);
    doReset(1'b1);
    applyStimulus(4'b0001, 1'b0, 0, 0);
    checkOutput();
    checkVal("restart_addr", int'(bus.alloc_addr), 0);
    endCycle();

    // Random traffic: a low-free phase drains the list, then a high-free phase refills it.
    doReset(1'b1);
    for (int c = 0; c < 600; c++) begin
      r_srdy = 4'($urandom);
      r_fs   = 1'b0;
      r_fa   = 0;
      r_fp   = 0;
      if ($urandom_range(0, 31) == 0) begin
        r_fs = 1'b1;
        r_fa = int'($urandom_range(0, PB_DEPTH - 1));
        r_fp = int'($urandom_range(0, NUM_PORTS - 1));
      end else if (m_out.size() > 0 &&
                   $urandom_range(0, 3) < ((c < 300) ? 1 : 3)) begin
        r_idx = int'($urandom_range(0, m_out.size() - 1));
        r_fs  = 1'b1;
        r_fa  = m_out[r_idx].addr;
        r_fp  = m_out[r_idx].port;
        m_out.delete(r_idx);
      end
      runCycle(r_srdy, r_fs, r_fa, r_fp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_alloc.md
Name: pb_alloc

Overview:
Free-line allocator and per-port admission controller for the shared packet buffer. It hands out buffer line addresses to NUM_PORTS write requesters using round-robin arbitration with a per-port occupancy quota. It reclaims lines when the read side has drained them. Sits beside the packet-buffer arbiter/scoreboard: ports obtain a line here before issuing a PBR write, and the read-return path frees the line after delivery.

Parameters:
NUM_PORTS, 4, number of requesting ports
PORT_ASZ, 2, port index width, equal to clog2(NUM_PORTS)
PB_DEPTH, 64, number of buffer lines managed
PB_ASZ, 6, line address width, equal to clog2(PB_DEPTH)
QUOTA, 24, maximum lines held by one port at once (1..PB_DEPTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset; 0 resets all state
alloc_srdy  in  NUM_PORTS  per-port allocation request
alloc_drdy  out  NUM_PORTS  one-hot grant; a transfer occurs when alloc_srdy[p] and alloc_drdy[p] are both 1
alloc_addr  out  PB_ASZ  allocated line address, valid while any alloc_drdy bit is 1
free_srdy  in  1  line return request
free_drdy  out  1  free accepted
free_addr  in  PB_ASZ  line being returned
free_port  in  PORT_ASZ  port that owned the line being returned
init_done  out  1  free list populated; allocation enabled
free_count  out  PB_ASZ+1  number of lines currently on the free list
err  out  1  sticky protocol error flag, cleared only by reset

Behaviour:
- Reset values: init_done=0, free_count=0, alloc_drdy=0, free_drdy=0, err=0, RR pointer=0, all port_used counters=0, head=tail=0.
- Free list: circular FIFO of PB_DEPTH entries, each PB_ASZ bits wide, with head and tail pointers. Pointers wrap modulo PB_DEPTH.
- State machine: INIT -> RUN.
  - INIT: write entry i = i for i = 0..PB_DEPTH-1, one per cycle, with free_count incrementing each cycle.
  - After the PB_DEPTH-th write, move to RUN, set init_done=1, free_count=PB_DEPTH. init_done therefore rises PB_DEPTH cycles after reset deasserts.
  - In INIT, alloc_drdy=0 and free_drdy=0.
- Eligibility in RUN: port p is eligible when alloc_srdy[p]=1 and port_used[p] < QUOTA.
- Grant in RUN: when free_count > 0, exactly one eligible port receives alloc_drdy, chosen round-robin starting from the RR pointer. Zero-latency: grant and alloc_addr = list[head] are combinational in the same cycle.
- On an alloc transfer: head++, free_count--, port_used[p]++, and the RR pointer becomes (p+1) mod NUM_PORTS. Without a transfer the RR pointer holds.
- alloc_drdy never asserts for a port whose alloc_srdy=0. No grant is issued when free_count==0 or no port is eligible.
- Free path: free_drdy = 1 whenever in RUN. On a free transfer: list[tail]=free_addr, tail++, free_count++, port_used[free_port]--.
- Simultaneous alloc and free in one cycle: both take effect. free_count and the affected port_used values change by the net amount. A free does not bypass to a same-cycle alloc, so a cycle starting with free_count==0 grants nothing even if a free arrives.
- Error cases: a free with free_count==PB_DEPTH, or with port_used[free_port]==0, sets err=1. The operation is dropped: the list and counters are unchanged. free_drdy still acknowledges it.
- Reset asserted mid-operation: all state clears asynchronously. INIT restarts after reset deasserts.
- Width rules: free_count and port_used use saturating-safe widths of PB_ASZ+1 bits. Comparisons are unsigned.

Decomposition:
- Shared package/defines: NUM_PORTS, PORT_ASZ, PB_DEPTH, PB_ASZ (reuse the existing packet-buffer constants), plus the state encodings ST_INIT and ST_RUN.
- One natural sub-module: pb_rr_arb. It takes a NUM_PORTS eligibility vector and the RR pointer, and produces the one-hot grant plus the encoded winner. The free-list FIFO and counters stay in pb_alloc.

Test Plan:
- Reset release, no requests -> init_done rises exactly 64 cycles later; free_count=64; err=0.
- Port 0 requests continuously alone -> alloc_addr sequence 0,1,2,...,23 on consecutive cycles; then alloc_drdy[0]=0 (quota 24); free_count=40.
- All four ports request continuously from the RUN start -> grants one-hot in order 0,1,2,3,0,1 with addresses 0..5.
- Drain to free_count=0 using quotas across ports. Then one free(addr=7) with port 2 requesting in the same cycle -> no grant that cycle; next cycle port 2 is granted addr 7.
- free_count=1 with alloc and free in the same cycle -> both accepted; free_count stays 1; the granted address is the old head.
- Free with port_used[free_port]==0 -> err=1 and counters unchanged. Then assert reset during INIT at cycle 10 -> init_done=0, err=0, and INIT restarts from entry 0.
